// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment patterns
// (bit0=a .. bit6=g) and the two-state scan FSM encoding.
package sevenseg_pkg;

   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0011000;
   localparam logic [6:0] SEG_A   = 7'b0001000;
   localparam logic [6:0] SEG_B   = 7'b0000011;
   localparam logic [6:0] SEG_C   = 7'b1000110;
   localparam logic [6:0] SEG_D   = 7'b0100001;
   localparam logic [6:0] SEG_E   = 7'b0000110;
   localparam logic [6:0] SEG_F   = 7'b0001110;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef logic [0:0] state_t;
   localparam state_t ST_BLANK = 1'b0;
   localparam state_t ST_DRIVE = 1'b1;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
   import sevenseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_OFF;
      case (nibble)
         4'h0: seg_n = SEG_0;
         4'h1: seg_n = SEG_1;
         4'h2: seg_n = SEG_2;
         4'h3: seg_n = SEG_3;
         4'h4: seg_n = SEG_4;
         4'h5: seg_n = SEG_5;
         4'h6: seg_n = SEG_6;
         4'h7: seg_n = SEG_7;
         4'h8: seg_n = SEG_8;
         4'h9: seg_n = SEG_9;
         4'hA: seg_n = SEG_A;
         4'hB: seg_n = SEG_B;
         4'hC: seg_n = SEG_C;
         4'hD: seg_n = SEG_D;
         4'hE: seg_n = SEG_E;
         default: seg_n = SEG_F;
      endcase
   end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed common-anode display scanner with per-digit blanking gap, leading-zero
// suppression and a valid/ready load port whose words take effect only at frame start.
module sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int PRESCALE    = 5000,
   parameter int ON_TICKS    = 4,
   parameter int BLANK_TICKS = 1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic                    lzs,
   output logic [6:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_start
);

   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int PW   = $clog2(PRESCALE);
   localparam int TMAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   logic [PW-1:0]           pcnt;
   logic [TW-1:0]           tcnt;
   logic [IW-1:0]           idx;
   state_t                  state;
   logic [4*NUM_DIGITS-1:0] disp;
   logic [4*NUM_DIGITS-1:0] pend_data;
   logic                    pend;
   logic                    lzs_c;

   logic                    tick;
   logic                    last_tick;
   logic                    idx_last;
   logic                    enter_frame;
   logic                    accept;
   logic                    show;
   logic [NUM_DIGITS-1:0]   supp;
   logic                    zero_above;
   logic [6:0]              dec_seg;

   assign tick        = (pcnt == PW'(PRESCALE - 1));
   assign last_tick   = tick && ((state == ST_DRIVE) ? (tcnt == TW'(ON_TICKS - 1))
                                                     : (tcnt == TW'(BLANK_TICKS - 1)));
   assign idx_last    = (idx == IW'(NUM_DIGITS - 1));
   assign enter_frame = last_tick && (state == ST_BLANK) && idx_last;
   assign accept      = load_valid && load_ready;

   // Digit k is dark when it and every more-significant nibble are zero; digit 0 never is.
   always_comb begin
      zero_above = 1'b1;
      supp       = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above && (disp[4*k +: 4] == 4'h0);
         supp[k]    = lzs_c && (k != 0) && zero_above;
      end
   end

   seg7_decode u_dec (
      .nibble (disp[{idx, 2'b00} +: 4]),
      .seg_n  (dec_seg)
   );

   assign show = (state == ST_DRIVE) && !supp[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt  <= '0;
         tcnt  <= '0;
         idx   <= IW'(NUM_DIGITS - 1);
         state <= ST_BLANK;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         if (last_tick) begin
            tcnt <= '0;
            if (state == ST_BLANK) begin
               state <= ST_DRIVE;
               idx   <= idx_last ? '0 : idx + 1'b1;
            end else begin
               state <= ST_BLANK;
            end
         end else if (tick) begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

   // load_ready mirrors !pend, so accept and commit can never fire together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp       <= '0;
         pend_data  <= '0;
         pend       <= 1'b0;
         lzs_c      <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         if (accept) begin
            pend_data  <= load_data;
            pend       <= 1'b1;
            load_ready <= 1'b0;
         end else if (enter_frame && pend) begin
            disp       <= pend_data;
            lzs_c      <= lzs;
            pend       <= 1'b0;
            load_ready <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_n        <= '1;
         seg_n       <= SEG_OFF;
         frame_start <= 1'b0;
      end else begin
         an_n        <= show ? ~(NUM_DIGITS'(1) << idx) : '1;
         seg_n       <= show ? dec_seg : SEG_OFF;
         // Only the first cycle of digit 0 DRIVE has every counter at zero.
         frame_start <= (state == ST_DRIVE) && (idx == '0) && (tcnt == '0) && (pcnt == '0);
      end
   end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Time-multiplexed seven-segment display controller for the MAX10 board examples. It scans `NUM_DIGITS` common-anode digits through a single shared hex-to-segment decoder. It inserts a blanking gap between digits to suppress ghosting. New display values arrive over a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4: digits scanned, 2..8.
- `PRESCALE`, 5000: clk cycles per scan tick, ≥2.
- `ON_TICKS`, 4: ticks each digit is driven, ≥1.
- `BLANK_TICKS`, 1: ticks of all-off gap after each digit, ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_data`  in  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit.
- `load_valid`  in  1  load_data valid.
- `load_ready`  out  1  controller can accept a word.
- `lzs`  in  1  leading-zero suppression enable; sampled at commit.
- `seg_n`  out  7  active-low segments, bit0=a … bit6=g.
- `an_n`  out  NUM_DIGITS  active-low digit enables.
- `frame_start`  out  1  one-cycle pulse on entry to DRIVE of digit 0.

## Operation
- Prescaler counts 0..PRESCALE-1 and wraps. `tick` = (count==PRESCALE-1).
- FSM states are BLANK and DRIVE, with digit index `idx` and tick counter `tcnt`.
  - BLANK: `an_n` all 1 and `seg_n`=7'h7F. After BLANK_TICKS ticks, go to DRIVE.
  - Leaving BLANK with `idx`==NUM_DIGITS-1 wraps `idx` to 0. Otherwise `idx` increments. Reset is the special case: the first BLANK→DRIVE enters digit 0.
  - DRIVE: `seg_n`=decode(disp[idx]). `an_n[idx]`=0 unless digit idx is suppressed. After ON_TICKS ticks, go to BLANK.
- Decoder is active-low. 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0011000, A→0001000, B→0000011, C→1000110, D→0100001, E→0000110, F→0001110.
- Suppression (`lzs_c`=1): digit k is suppressed if k≠0 and every nibble j≥k is zero. A suppressed slot keeps its timing but has `an_n` all 1 and `seg_n`=7'h7F. Digit 0 always shows.
- Handshake:
  - Accept = `load_valid`&&`load_ready`. Accepted data goes to a pending register, sets `pend`, and drops `load_ready`.
  - Commit happens on the BLANK→DRIVE transition into digit 0. If `pend` is set, `disp`←pending, `lzs_c`←`lzs`, and `pend` is cleared.
  - A word accepted in the commit cycle waits for the next frame.
  - `load_valid` may drop without acceptance. There is no data-stability requirement while `load_ready`=0.

## Timing
- Reset values: `an_n`=all 1, `seg_n`=7'h7F, `load_ready`=1, `frame_start`=0. Internal: `disp`=0, `pend`=0, `lzs_c`=0, state BLANK, `idx`=NUM_DIGITS-1, prescaler=0, `tcnt`=0.
- The first DRIVE of digit 0 begins BLANK_TICKS*PRESCALE cycles after reset release.
- All outputs are registered and change on the clk edge after the FSM transition. There is one cycle of latency from the internal tick to the pins.
- `load_ready` is 0 from the cycle after acceptance through the commit cycle. It returns to 1 the cycle after commit.
- Committed data is visible on `seg_n` in the same edge update that asserts `frame_start`.
- Digit period = (ON_TICKS+BLANK_TICKS)*PRESCALE clk cycles. Frame period = NUM_DIGITS times the digit period.
- Asserting `rst_n` low mid-frame forces reset values immediately, with no clock. A pending word is discarded.

## Structure
- Package `sevenseg_pkg`:
  - Segment pattern constants for 0-F and `SEG_OFF`=7'h7F.
  - FSM state typedef.
- Sub-module `seg7_decode`: combinational nibble→active-low segments, one instance fed by `disp[idx]`.
- The top contains the prescaler, FSM, pending/commit registers, suppression logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, PRESCALE=4, ON_TICKS=2, BLANK_TICKS=1.
- Reset: hold `rst_n`=0 → `an_n`=4'b1111, `seg_n`=7'h7F, `load_ready`=1. Release → first `frame_start` 4 cycles later.
- Load 16'h1234, lzs=0, then run a frame:
  - Digit 0: `an_n`=1110, `seg_n`=0011001 for 8 cycles, then a 4-cycle blank with `an_n`=1111.
  - Digit 1: `an_n`=1101, `seg_n`=0110000.
  - Digits 2 and 3 follow the same pattern.
- Load 16'h0070 with lzs=1 → digits 3 and 2 stay dark for their slots. Digit 1 shows 1111000. Digit 0 shows 1000000.
- Back-to-back loads 16'hAAAA then 16'hBBBB with `load_valid` held high:
  - `load_ready` stays 0 until the commit.
  - Every digit of one frame shows 0001000; BBBB appears only at the next frame.
  - No mixed frame occurs.
- Pulse `rst_n` low mid-DRIVE of digit 2 with a pending word → outputs return to reset values asynchronously. The pending word never displays; `disp` returns to 0.
- Sweep nibble 0 over 0..F across 16 frames → `seg_n` matches the decoder list exactly, e.g. F→0001110.
